// File: rtl/mouse_pkg.sv
// Shared types and byte-field positions for the mouse packet tracker.
package mouse_pkg;

  typedef enum logic [1:0] {
    BYTE0  = 2'd0,
    BYTE1  = 2'd1,
    BYTE2  = 2'd2,
    UPDATE = 2'd3
  } state_e;

  localparam int SYNC_BIT  = 3;
  localparam int BTN_BIT   = 0;
  localparam int XSIGN_BIT = 4;
  localparam int XOVF_BIT  = 6;

  typedef logic signed [8:0] delta_t;

endpackage

// File: rtl/mouse_x_accumulator.sv
// Combinational X update: scale the signed delta, add to the current X, clamp to [0, X_MAX].
module mouse_x_accumulator
  import mouse_pkg::*;
#(
  parameter int X_MAX       = 639,
  parameter int SPEED_SHIFT = 0
) (
  input  logic [15:0] mouse_x,
  input  delta_t      delta,
  output logic [15:0] next_x
);

  logic signed [17:0] delta_ext;
  logic signed [17:0] sum;

  // 18 bits cover a 16-bit position plus a 13-bit scaled delta without wrap.
  always_comb begin
    delta_ext = 18'(delta) <<< SPEED_SHIFT;
    sum       = $signed({2'b00, mouse_x}) + delta_ext;
    if (sum < 18'sd0) begin
      next_x = 16'd0;
    end else if (sum > 18'(X_MAX)) begin
      next_x = 16'(X_MAX);
    end else begin
      next_x = sum[15:0];
    end
  end

endmodule

// File: rtl/mouse_tracker.sv
// Assembles 3-byte mouse packets into a clamped absolute X position and button level.
// Optional build macro MOUSE_TRACKER_DEBOUNCE_EN debounces the button across packets.
module mouse_tracker
  import mouse_pkg::*;
#(
  parameter int X_MAX          = 639,
  parameter int X_RESET        = 320,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SPEED_SHIFT    = 0
) (
  input  logic        clock,
  input  logic        reset_,
  // A byte moves on a posedge where in_valid && in_ready; upstream holds in_data
  // stable while in_valid && !in_ready, and in_ready is low only in UPDATE.
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mouse_pressed_,
  output logic [15:0] mouse_x,
  output logic        packet_valid,
  output logic [1:0]  dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state, state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          xfer;
  logic          btn, xsign, xovf;
  logic [7:0]    dx;
  delta_t        delta;
  logic [15:0]   next_x;

  assign in_ready  = (state != UPDATE);
  assign xfer      = in_valid && in_ready;
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign dbg_state = state;
  assign delta     = xovf ? delta_t'(0) : delta_t'({xsign, dx});

  always_comb begin
    state_nxt = state;
    case (state)
      BYTE0:   if (xfer && in_data[SYNC_BIT]) state_nxt = BYTE1;
      BYTE1:   if (xfer) state_nxt = BYTE2;  else if (tmo_hit) state_nxt = BYTE0;
      BYTE2:   if (xfer) state_nxt = UPDATE; else if (tmo_hit) state_nxt = BYTE0;
      UPDATE:  state_nxt = BYTE0;
      default: state_nxt = BYTE0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_) begin
      state        <= BYTE0;
      tmo_cnt      <= '0;
      btn          <= 1'b0;
      xsign        <= 1'b0;
      xovf         <= 1'b0;
      dx           <= 8'd0;
      mouse_x      <= 16'(X_RESET);
      packet_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      packet_valid <= (state == UPDATE);
      // A transfer on the timeout cycle wins, so the count clears either way.
      if (state == BYTE1 || state == BYTE2) begin
        tmo_cnt <= (xfer || tmo_hit) ? '0 : tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
      if (state == BYTE0 && xfer && in_data[SYNC_BIT]) begin
        btn   <= in_data[BTN_BIT];
        xsign <= in_data[XSIGN_BIT];
        xovf  <= in_data[XOVF_BIT];
      end
      if (state == BYTE1 && xfer) dx <= in_data;
      if (state == UPDATE) mouse_x <= next_x;
    end
  end

`ifdef MOUSE_TRACKER_DEBOUNCE_EN
  logic btn_cand, cand_seen;

  // A new level must arrive in two applied packets back to back before it is taken.
  always_ff @(posedge clock) begin
    if (reset_) begin
      mouse_pressed_ <= 1'b0;
      btn_cand       <= 1'b0;
      cand_seen      <= 1'b0;
    end else if (state == UPDATE) begin
      if (btn == mouse_pressed_) begin
        cand_seen <= 1'b0;
      end else if (cand_seen && btn_cand == btn) begin
        mouse_pressed_ <= btn;
        cand_seen      <= 1'b0;
      end else begin
        btn_cand  <= btn;
        cand_seen <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset_) begin
      mouse_pressed_ <= 1'b0;
    end else if (state == UPDATE) begin
      mouse_pressed_ <= btn;
    end
  end
`endif

  mouse_x_accumulator #(
    .X_MAX      (X_MAX),
    .SPEED_SHIFT(SPEED_SHIFT)
  ) u_acc (
    .mouse_x(mouse_x),
    .delta  (delta),
    .next_x (next_x)
  );

endmodule

// File: tb/tb_mouse_tracker.sv
// Directed bench for mouse_tracker: packets, clamps, resync, overflow, timeout, reset.
module tb_mouse_tracker;

  logic        clock;
  logic        reset_;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mouse_pressed_;
  logic [15:0] mouse_x;
  logic        packet_valid;
  logic [1:0]  dbg_state;

  int n_vec;
  int n_err;

  logic exp_pressed, m_cand, m_flag;

  mouse_tracker #(
    .X_MAX         (639),
    .X_RESET       (320),
    .TIMEOUT_CYCLES(8),
    .SPEED_SHIFT   (0)
  ) dut (
    .clock         (clock),
    .reset_        (reset_),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .mouse_pressed_(mouse_pressed_),
    .mouse_x       (mouse_x),
    .packet_valid  (packet_valid),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Expected button level after one applied packet.
  task automatic model_btn(input logic b);
`ifdef MOUSE_TRACKER_DEBOUNCE_EN
    if (b == exp_pressed) begin
      m_flag = 1'b0;
    end else if (m_flag && m_cand == b) begin
      exp_pressed = b;
      m_flag      = 1'b0;
    end else begin
      m_cand = b;
      m_flag = 1'b1;
    end
`else
    exp_pressed = b;
`endif
  endtask

  task automatic model_reset();
    exp_pressed = 1'b0;
    m_cand      = 1'b0;
    m_flag      = 1'b0;
  endtask

  // driver: called at a negedge, returns at the negedge after the transfer edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 10) begin
      @(negedge clock);
      n++;
    end
    if (n >= 10) check("ready_wait", 32'(in_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [15:0] exp_x);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    check("bubble_ready", 32'(in_ready), 32'd0);
    check("bubble_pv", 32'(packet_valid), 32'd0);
    @(negedge clock);
    model_btn(b0[0]);
    check("pv_pulse", 32'(packet_valid), 32'd1);
    check("mouse_x", 32'(mouse_x), 32'(exp_x));
    check("pressed", 32'(mouse_pressed_), 32'(exp_pressed));
    check("ready_back", 32'(in_ready), 32'd1);
    @(negedge clock);
    check("pv_single", 32'(packet_valid), 32'd0);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset_   = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    model_reset();
    repeat (3) @(negedge clock);
    reset_ = 1'b0;

    check("rst_x", 32'(mouse_x), 32'd320);
    check("rst_pressed", 32'(mouse_pressed_), 32'd0);
    check("rst_pv", 32'(packet_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);

    // basic moves
    send_packet(8'h09, 8'h0A, 8'h00, 16'd330);
    send_packet(8'h18, 8'hF6, 8'h00, 16'd320);

    // walk down to 5, then clamp at 0
    send_packet(8'h18, 8'h80, 8'h00, 16'd192);
    send_packet(8'h18, 8'h80, 8'h00, 16'd64);
    send_packet(8'h18, 8'hC5, 8'h00, 16'd5);
    send_packet(8'h18, 8'h80, 8'h00, 16'd0);

    // walk up to 600, then clamp at 639
    send_packet(8'h08, 8'h7F, 8'h00, 16'd127);
    send_packet(8'h08, 8'h7F, 8'h00, 16'd254);
    send_packet(8'h08, 8'h7F, 8'h00, 16'd381);
    send_packet(8'h08, 8'h7F, 8'h00, 16'd508);
    send_packet(8'h08, 8'h5C, 8'h00, 16'd600);
    send_packet(8'h08, 8'h7F, 8'h00, 16'd639);
    send_packet(8'h18, 8'h80, 8'h00, 16'd511);

    // resync: a byte without the sync bit is dropped
    send_byte(8'h00);
    check("resync_state", 32'(dbg_state), 32'd0);
    check("resync_pv", 32'(packet_valid), 32'd0);
    send_packet(8'h09, 8'h01, 8'h00, 16'd512);

    // overflow: delta ignored, pulse still fires
    send_packet(8'h48, 8'h7F, 8'h00, 16'd512);

    // timeout after 8 idle cycles in BYTE1
    send_byte(8'h08);
    for (int i = 0; i < 8; i++) begin
      check("tmo_no_pv", 32'(packet_valid), 32'd0);
      @(negedge clock);
    end
    check("tmo_state", 32'(dbg_state), 32'd0);
    check("tmo_x", 32'(mouse_x), 32'd512);
    send_packet(8'h08, 8'h05, 8'h00, 16'd517);

    // reset between byte1 and byte2
    send_byte(8'h08);
    send_byte(8'h05);
    reset_ = 1'b1;
    @(negedge clock);
    reset_ = 1'b0;
    model_reset();
    check("mid_rst_x", 32'(mouse_x), 32'd320);
    check("mid_rst_pressed", 32'(mouse_pressed_), 32'd0);
    check("mid_rst_pv", 32'(packet_valid), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    send_packet(8'h09, 8'h02, 8'h00, 16'd322);
    send_packet(8'h09, 8'h00, 8'h00, 16'd322);
    check("press_after_two", 32'(mouse_pressed_), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case a wait above never returns.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
